// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions.
// Holds the IF/ID bundle used between the fetch and decode stages.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] inst;
    logic            valid;
  } if_id_t;
endpackage

// File: rtl/pc_reg.sv
// Program counter register.
// Update priority: reset, redirect, stall, then increment.
module pc_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk) begin
    priority case (1'b1)
      rst:      pc <= RESET_PC;
      redirect: pc <= target;
      stall:    pc <= pc;
      default:  pc <= pc + 32'd4;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage.
// Drives the imem word address and captures the IF/ID register.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              IMEM_DEPTH = 256,
  parameter logic [XLEN-1:0] NOP = NOP_INST
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Stall,
  input  logic            Redirect,
  input  logic [XLEN-1:0] Redirect_PC,
  input  logic [XLEN-1:0] Imem_Inst,
  output logic [XLEN-1:0] Imem_Addr,
  output logic [XLEN-1:0] IF_PC,
  output logic [XLEN-1:0] IF_PC4,
  output logic [XLEN-1:0] IF_Inst,
  output logic            IF_Valid,
  output logic            Misalign,
  output logic            Fetch_Fault
);

  localparam logic [XLEN-1:0] DEPTH = 32'(IMEM_DEPTH);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] target;
  logic            oor;
  if_id_t          q;

  assign target = {Redirect_PC[31:2], 2'b00};

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk     (CLK),
    .rst     (RST),
    .stall   (Stall),
    .redirect(Redirect),
    .target  (target),
    .pc      (pc)
  );

  // Depends on PC only, so no path from Stall/Redirect.
  assign Imem_Addr = {2'b00, pc[31:2]};
  assign oor = Imem_Addr >= DEPTH;

  always_ff @(posedge CLK) begin
    priority case (1'b1)
      RST: begin
        q           <= '{pc: '0, pc4: '0,
                         inst: NOP, valid: 1'b0};
        Misalign    <= 1'b0;
        Fetch_Fault <= 1'b0;
      end
      Redirect: begin
        q        <= '{pc: '0, pc4: '0,
                      inst: NOP, valid: 1'b0};
        Misalign <= |Redirect_PC[1:0];
      end
      Stall: begin
        Misalign <= 1'b0;
      end
      default: begin
        q.pc     <= pc;
        q.pc4    <= pc + 32'd4;
        q.inst   <= oor ? NOP : Imem_Inst;
        q.valid  <= ~oor;
        Misalign <= 1'b0;
        if (oor) Fetch_Fault <= 1'b1;
      end
    endcase
  end

  assign IF_PC    = q.pc;
  assign IF_PC4   = q.pc4;
  assign IF_Inst  = q.inst;
  assign IF_Valid = q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage.
// Directed and random steps checked against a behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] NOPI = 32'h0000_0013;
  localparam logic [31:0] RPC  = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Stall = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] Redirect_PC = '0;
  logic [31:0] Imem_Inst;
  logic [31:0] Imem_Addr;
  logic [31:0] IF_PC, IF_PC4, IF_Inst;
  logic        IF_Valid, Misalign, Fetch_Fault;

  logic [31:0] mem [256];

  int nchk = 0;
  int nfail = 0;

  logic [31:0] m_pc, m_ipc, m_ipc4, m_inst;
  logic        m_v, m_mis, m_flt;

  fetch_stage #(
    .RESET_PC  (RPC),
    .IMEM_DEPTH(256),
    .NOP       (NOPI)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .Redirect_PC(Redirect_PC),
    .Imem_Inst  (Imem_Inst),
    .Imem_Addr  (Imem_Addr),
    .IF_PC      (IF_PC),
    .IF_PC4     (IF_PC4),
    .IF_Inst    (IF_Inst),
    .IF_Valid   (IF_Valid),
    .Misalign   (Misalign),
    .Fetch_Fault(Fetch_Fault)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    if (Imem_Addr < 32'd256) Imem_Inst = mem[Imem_Addr[7:0]];
    else Imem_Inst = 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("imem_addr", Imem_Addr, m_pc >> 2);
    chk("if_pc", IF_PC, m_ipc);
    chk("if_pc4", IF_PC4, m_ipc4);
    chk("if_inst", IF_Inst, m_inst);
    chk("if_valid", 32'(IF_Valid), 32'(m_v));
    chk("misalign", 32'(Misalign), 32'(m_mis));
    chk("fault", 32'(Fetch_Fault), 32'(m_flt));
  endtask

  task automatic step(input logic r, input logic s,
                      input logic d, input logic [31:0] rp);
    @(negedge CLK);
    RST = r;
    Stall = s;
    Redirect = d;
    Redirect_PC = rp;
    if (r) begin
      m_pc = RPC;
      m_ipc = 0;
      m_ipc4 = 0;
      m_inst = NOPI;
      m_v = 0;
      m_mis = 0;
      m_flt = 0;
    end else if (d) begin
      m_pc = rp & ~32'd3;
      m_ipc = 0;
      m_ipc4 = 0;
      m_inst = NOPI;
      m_v = 0;
      m_mis = (rp % 4) != 0;
    end else if (s) begin
      m_mis = 0;
    end else begin
      m_ipc = m_pc;
      m_ipc4 = m_pc + 4;
      m_mis = 0;
      if ((m_pc / 4) >= 256) begin
        m_inst = NOPI;
        m_v = 0;
        m_flt = 1;
      end else begin
        m_inst = mem[m_pc / 4];
        m_v = 1;
      end
      m_pc = m_pc + 4;
    end
    @(posedge CLK);
    #1;
    chk_all();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;
    mem[2] = 32'h0020_81B3;
    mem[3] = 32'h0000_006F;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_inst", IF_Inst, NOPI);

    step(0, 0, 0, 0);
    chk("first_inst", IF_Inst, 32'h0050_0093);
    chk("first_valid", 32'(IF_Valid), 32'd1);
    step(0, 0, 0, 0);
    chk("addr_at_8", Imem_Addr, 32'd2);

    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    chk("stall_pc", IF_PC, 32'd4);
    chk("stall_inst", IF_Inst, 32'h00A0_0113);
    step(0, 0, 0, 0);
    chk("release_pc", IF_PC, 32'd8);
    step(0, 0, 0, 0);

    step(0, 1, 1, 32'h40);
    chk("redir_addr", Imem_Addr, 32'h10);
    step(0, 0, 0, 0);
    chk("redir_pc", IF_PC, 32'h40);

    step(0, 0, 1, 32'h42);
    chk("mis_pulse", 32'(Misalign), 32'd1);
    step(0, 0, 0, 0);
    chk("mis_clear", 32'(Misalign), 32'd0);

    for (int i = 0; i < 300; i++) begin
      logic s, d;
      logic [31:0] rp;
      s = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 7) == 0);
      rp = $urandom_range(0, 32'h3FF);
      step(0, s, d, rp);
    end

    step(0, 0, 1, 32'h3F8);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    chk("oor_fault", 32'(Fetch_Fault), 32'd1);
    chk("oor_valid", 32'(IF_Valid), 32'd0);
    step(0, 0, 1, 32'h10);
    step(0, 0, 0, 0);
    chk("fault_sticky", 32'(Fetch_Fault), 32'd1);

    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("wrap_addr", Imem_Addr, 32'd1);

    step(1, 0, 0, 0);
    chk("rst_fault", 32'(Fetch_Fault), 32'd0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    step(1, 1, 1, 32'h80);
    chk("rst_redir_addr", Imem_Addr, 32'd0);
    step(0, 0, 0, 0);
    chk("after_rst_pc", IF_PC, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
